// File: rtl/square_plotter.sv
// square_plotter: walks the pixels of one square-draw command in row-major
// order and presents them to the VGA adapter. Pixels beyond the visible
// frame are still walked, one cycle each, but their write strobe is held low.
// A command is taken over a valid/ready handshake. done pulses once the
// square has been fully walked.

module square_plotter #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [1:0] cmd_size,
  input  logic [2:0] cmd_colour,
  input  logic       cmd_erase,
  input  logic       draw_en,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       done,
  output logic       busy
);

  // The frame limits are compared against sums one bit wider than the
  // coordinates, so an origin near the edge never wraps back into view.
  localparam logic [8:0] X_LIMIT = 9'(X_MAX);
  localparam logic [7:0] Y_LIMIT = 8'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Command fields captured at acceptance; the command inputs are not
  // looked at again until the next acceptance.
  logic [7:0] org_x;
  logic [6:0] org_y;
  logic [4:0] last_idx;
  logic [2:0] fill_colour;

  // Offset of the current pixel inside the square.
  logic [4:0] col;
  logic [4:0] row;

  logic       accept;
  logic       reserved_size;
  logic [4:0] size_last_idx;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_frame;
  logic       last_col;
  logic       last_pix;
  logic       step;

  // Handshake, size decode, pixel address arithmetic and walk-end detection.
  always_comb begin
    accept        = cmd_valid & cmd_ready;
    reserved_size = (cmd_size == 2'b11);
    size_last_idx = 5'd0;
    case (cmd_size)
      2'b00:   size_last_idx = 5'd3;
      2'b01:   size_last_idx = 5'd9;
      2'b10:   size_last_idx = 5'd19;
      default: size_last_idx = 5'd0;
    endcase
    sum_x    = {1'b0, org_x} + {4'b0000, col};
    sum_y    = {1'b0, org_y} + {3'b000, row};
    in_frame = (sum_x <= X_LIMIT) && (sum_y <= Y_LIMIT);
    last_col = (col == last_idx);
    last_pix = last_col && (row == last_idx);
    step     = (state == DRAW) && draw_en;
  end

  // Next-state logic: a reserved size skips straight to FINISH.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = reserved_size ? FINISH : DRAW;
        end
      end
      DRAW: begin
        if (draw_en && last_pix) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the command at acceptance, forcing black when erasing.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      org_x       <= 8'd0;
      org_y       <= 7'd0;
      last_idx    <= 5'd0;
      fill_colour <= 3'd0;
    end else if (accept) begin
      org_x       <= cmd_x;
      org_y       <= cmd_y;
      last_idx    <= size_last_idx;
      fill_colour <= cmd_erase ? 3'b000 : cmd_colour;
    end
  end

  // Column/row walk: column fastest, wrapping into the next row.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col <= 5'd0;
      row <= 5'd0;
    end else if (accept) begin
      col <= 5'd0;
      row <= 5'd0;
    end else if (step) begin
      if (last_pix) begin
        col <= 5'd0;
        row <= 5'd0;
      end else if (last_col) begin
        col <= 5'd0;
        row <= row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end

  // Registered pixel outputs; a stall keeps the address but drops the strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      plot       <= 1'b0;
    end else begin
      plot <= 1'b0;
      if (step) begin
        vga_x      <= sum_x[7:0];
        vga_y      <= sum_y[6:0];
        vga_colour <= fill_colour;
        plot       <= in_frame;
      end
    end
  end

  // Handshake flags: ready only in an idle cycle not already accepting,
  // busy held from acceptance through the done cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmd_ready <= (state == IDLE) && !accept;
      busy      <= (state != IDLE) || accept;
      done      <= (state == FINISH);
    end
  end

endmodule

// File: tb/tb_square_plotter.sv
// tb_square_plotter: drives square commands (directed and random) into
// square_plotter and compares the plotted pixel stream and handshake timing
// against a pixel list built directly from the square geometry.

module tb_square_plotter;

  logic       clock;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [1:0] cmd_size;
  logic [2:0] cmd_colour;
  logic       cmd_erase;
  logic       draw_en;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       done;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Results of the most recent command, filled in by run_cmd.
  logic [17:0] obs_q[$];
  logic [17:0] exp_q[$];
  int  done_t, ready_t, n_done, overlap, busy_err, stall_err;
  int  first_plot_t, last_plot_t, wait_cycles, exp_done_t;
  bit  timed_out, acc_ok;

  square_plotter #(.X_MAX(159), .Y_MAX(119)) dut (
    .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size), .cmd_colour(cmd_colour),
    .cmd_erase(cmd_erase), .draw_en(draw_en), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .done(done), .busy(busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int side_of(input logic [1:0] size);
    case (size)
      2'b00:   return 4;
      2'b01:   return 10;
      2'b10:   return 20;
      default: return 0;
    endcase
  endfunction

  // Reference: every pixel of the square in row-major order, keeping only
  // those inside the 160x120 frame.
  task automatic build_expected(input logic [7:0] x, input logic [6:0] y,
                                input logic [1:0] size, input logic [2:0] c,
                                input bit erase);
    int n;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    n = side_of(size);
    exp_q.delete();
    pc = erase ? 3'b000 : c;
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < n; k++) begin
        if ((int'(x) + k) <= 159 && (int'(y) + r) <= 119) begin
          px = 8'(int'(x) + k);
          py = 7'(int'(y) + r);
          exp_q.push_back({px, py, pc});
        end
      end
    end
  endtask

  // Issue one command and record everything that comes out until ready.
  // stall_mode: 0 = draw_en high, 1 = low on odd edges, 2 = random.
  task automatic run_cmd(input logic [7:0] x, input logic [6:0] y,
                         input logic [1:0] size, input logic [2:0] c,
                         input bit erase, input int stall_mode, input bit mid_valid);
    int need, en_count, draw_end, limit;
    bit en;
    need = side_of(size) * side_of(size);
    obs_q.delete();
    done_t = -1; ready_t = -1; n_done = 0; overlap = 0; busy_err = 0;
    stall_err = 0; first_plot_t = -1; last_plot_t = -1; wait_cycles = 0;
    timed_out = 0; acc_ok = 0;
    while (cmd_ready !== 1'b1 && wait_cycles < 300) begin
      @(negedge clock);
      wait_cycles++;
    end
    cmd_x = x; cmd_y = y; cmd_size = size; cmd_colour = c; cmd_erase = erase;
    cmd_valid = 1'b1;
    draw_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    acc_ok = (cmd_ready === 1'b0) && (busy === 1'b1);
    cmd_valid = 1'b0;
    cmd_x = 8'($urandom); cmd_y = 7'($urandom); cmd_size = 2'($urandom);
    cmd_colour = 3'($urandom); cmd_erase = 1'($urandom);
    en_count = 0;
    draw_end = (need == 0) ? 0 : -1;
    limit = 2 * need + 60;
    for (int i = 1; i <= limit; i++) begin
      case (stall_mode)
        1:       en = (i % 2 == 0);
        2:       en = ($urandom_range(0, 3) != 0);
        default: en = 1'b1;
      endcase
      draw_en = en;
      cmd_valid = mid_valid && (i == 5);
      if (mid_valid && i == 5) begin
        cmd_x = x + 8'd3; cmd_y = y + 7'd2; cmd_size = 2'b11;
        cmd_colour = ~c; cmd_erase = ~erase;
      end
      if (draw_end < 0 && en) begin
        en_count++;
        if (en_count == need) draw_end = i;
      end
      @(posedge clock);
      @(negedge clock);
      if (plot === 1'b1) begin
        obs_q.push_back({vga_x, vga_y, vga_colour});
        if (first_plot_t < 0) first_plot_t = i;
        last_plot_t = i;
        if (!en) stall_err++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_t < 0) done_t = i;
        if (plot === 1'b1) overlap++;
      end
      if (cmd_ready === 1'b1) begin
        ready_t = i;
        if (busy !== 1'b0) busy_err++;
        break;
      end else if (busy !== 1'b1) begin
        busy_err++;
      end
    end
    cmd_valid = 1'b0;
    draw_en = 1'b1;
    if (ready_t < 0) timed_out = 1;
    exp_done_t = draw_end + 1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; cmd_valid = 1'b0; draw_en = 1'b1;
    cmd_x = 8'd0; cmd_y = 7'd0; cmd_size = 2'd0; cmd_colour = 3'd0; cmd_erase = 1'b0;
    #35;
    checks++;
    if ({cmd_ready, plot, done, busy, vga_x, vga_y, vga_colour} !== 22'd0) begin
      failures++;
      $display("FAIL reset_values: got %b, wanted all zero",
               {cmd_ready, plot, done, busy, vga_x, vga_y, vga_colour});
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b, wanted 0", cmd_ready);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_release: got ready=%b busy=%b, wanted 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_small_square;
    int bad;
    run_cmd(8'd10, 7'd20, 2'b00, 3'd5, 1'b0, 0, 1'b0);
    build_expected(8'd10, 7'd20, 2'b00, 3'd5, 1'b0);
    checks++;
    if (timed_out || !acc_ok) begin
      failures++;
      $display("FAIL small_handshake: got timeout=%0d accept=%0d, wanted 0 1", timed_out, acc_ok);
    end
    checks++;
    if (obs_q.size() != 16 || first_plot_t != 1 || last_plot_t != 16) begin
      failures++;
      $display("FAIL small_plot_run: got %0d plots edges %0d..%0d, wanted 16 plots edges 1..16",
               obs_q.size(), first_plot_t, last_plot_t);
    end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL small_pixels: got %0d wrong of %0d, wanted 0 wrong of %0d",
               bad, obs_q.size(), exp_q.size());
    end
    checks++;
    if (done_t != 17 || ready_t != 18 || n_done != 1 || overlap != 0 || busy_err != 0) begin
      failures++;
      $display("FAIL small_timing: got done@%0d ready@%0d n_done=%0d overlap=%0d busy_err=%0d, wanted 17 18 1 0 0",
               done_t, ready_t, n_done, overlap, busy_err);
    end
  endtask

  task automatic test_clip;
    int bad;
    logic [2:0] c;
    c = 3'($urandom);
    run_cmd(8'd150, 7'd110, 2'b10, c, 1'b0, 0, 1'b0);
    build_expected(8'd150, 7'd110, 2'b10, c, 1'b0);
    checks++;
    if (obs_q.size() != 100 || exp_q.size() != 100) begin
      failures++;
      $display("FAIL clip_count: got %0d plots, wanted 100", obs_q.size());
    end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clip_pixels: got %0d wrong pixels, wanted 0", bad);
    end
    checks++;
    if (done_t != 401 || ready_t != 402 || timed_out) begin
      failures++;
      $display("FAIL clip_timing: got done@%0d ready@%0d, wanted 401 402", done_t, ready_t);
    end
  endtask

  task automatic test_erase_ignore;
    int bad;
    run_cmd(8'd0, 7'd0, 2'b01, 3'd7, 1'b1, 0, 1'b1);
    build_expected(8'd0, 7'd0, 2'b01, 3'd7, 1'b1);
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] || obs_q[i][2:0] !== 3'b000) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 100) begin
      failures++;
      $display("FAIL erase_pixels: got %0d plots %0d wrong, wanted 100 plots 0 wrong",
               obs_q.size(), bad);
    end
    checks++;
    if (done_t != 101 || n_done != 1 || busy_err != 0) begin
      failures++;
      $display("FAIL erase_ignore_timing: got done@%0d n_done=%0d busy_err=%0d, wanted 101 1 0",
               done_t, n_done, busy_err);
    end
  endtask

  task automatic test_stall;
    int bad;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    x = 8'($urandom_range(0, 140)); y = 7'($urandom_range(0, 100)); c = 3'($urandom);
    run_cmd(x, y, 2'b01, c, 1'b0, 1, 1'b0);
    build_expected(x, y, 2'b01, c, 1'b0);
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 100) begin
      failures++;
      $display("FAIL stall_pixels: got %0d plots %0d wrong, wanted 100 plots 0 wrong",
               obs_q.size(), bad);
    end
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL stall_plot_low: got %0d plots on stalled edges, wanted 0", stall_err);
    end
    checks++;
    if (done_t != 201 || ready_t != 202) begin
      failures++;
      $display("FAIL stall_timing: got done@%0d ready@%0d, wanted 201 202", done_t, ready_t);
    end
  endtask

  task automatic test_reset_mid_draw;
    int plots, bad, guard;
    plots = 0; guard = 0;
    while (cmd_ready !== 1'b1 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    cmd_x = 8'd30; cmd_y = 7'd40; cmd_size = 2'b10; cmd_colour = 3'd6; cmd_erase = 1'b0;
    cmd_valid = 1'b1; draw_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    guard = 0;
    while (plots < 37 && guard < 500) begin
      @(posedge clock);
      @(negedge clock);
      if (plot === 1'b1) plots++;
      guard++;
    end
    checks++;
    if (plots != 37) begin
      failures++;
      $display("FAIL abort_reach_37: got %0d plots, wanted 37", plots);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, plot, done, busy, vga_x, vga_y, vga_colour} !== 22'd0) begin
      failures++;
      $display("FAIL abort_outputs: got %b, wanted all zero",
               {cmd_ready, plot, done, busy, vga_x, vga_y, vga_colour});
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || plot !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: got done=%b plot=%b, wanted 0 0", done, plot);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready_early: got %b, wanted 0", cmd_ready);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready_release: got %b, wanted 1", cmd_ready);
    end
    run_cmd(8'd5, 7'd6, 2'b00, 3'd3, 1'b0, 0, 1'b0);
    build_expected(8'd5, 7'd6, 2'b00, 3'd3, 1'b0);
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 16 || done_t != 17) begin
      failures++;
      $display("FAIL abort_redraw: got %0d plots %0d wrong done@%0d, wanted 16 0 17",
               obs_q.size(), bad, done_t);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    run_cmd(8'd44, 7'd33, 2'b11, 3'd2, 1'b0, 0, 1'b0);
    checks++;
    if (obs_q.size() != 0 || done_t != 1 || ready_t != 2 || n_done != 1) begin
      failures++;
      $display("FAIL reserved_size: got %0d plots done@%0d ready@%0d, wanted 0 1 2",
               obs_q.size(), done_t, ready_t);
    end
    run_cmd(8'd70, 7'd80, 2'b00, 3'd1, 1'b0, 0, 1'b0);
    build_expected(8'd70, 7'd80, 2'b00, 3'd1, 1'b0);
    checks++;
    if (wait_cycles != 0 || !acc_ok) begin
      failures++;
      $display("FAIL back_to_back_accept: got wait=%0d accept=%0d, wanted 0 1", wait_cycles, acc_ok);
    end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || obs_q.size() != 16 || done_t != 17) begin
      failures++;
      $display("FAIL back_to_back_pixels: got %0d plots %0d wrong done@%0d, wanted 16 0 17",
               obs_q.size(), bad, done_t);
    end
  endtask

  task automatic test_random;
    int bad;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] s;
    logic [2:0] c;
    bit e;
    for (int t = 0; t < 8; t++) begin
      x = 8'($urandom); y = 7'($urandom); s = 2'($urandom);
      c = 3'($urandom); e = 1'($urandom);
      run_cmd(x, y, s, c, e, 2, 1'b0);
      build_expected(x, y, s, c, e);
      bad = 0;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
        if (obs_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0 || obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL random_pixels[%0d]: got %0d plots %0d wrong, wanted %0d plots 0 wrong",
                 t, obs_q.size(), bad, exp_q.size());
      end
      checks++;
      if (done_t != exp_done_t || ready_t != exp_done_t + 1 || n_done != 1 ||
          overlap != 0 || stall_err != 0 || busy_err != 0) begin
        failures++;
        $display("FAIL random_timing[%0d]: got done@%0d ready@%0d stall_err=%0d, wanted done@%0d ready@%0d 0",
                 t, done_t, ready_t, stall_err, exp_done_t, exp_done_t + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_small_square();
    test_clip();
    test_erase_ignore();
    test_stall();
    test_reset_mid_draw();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
